// File: rtl/sa_psum_collector_pkg.sv
// Shared definitions for the systolic-array psum path: collector FSM encoding
// and default datapath widths, also used by the array controller.
package sa_psum_collector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } collector_state_t;

    localparam int DEF_PE_SIZE       = 2;
    localparam int DEF_PSUM_WIDTH    = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_ROW_CNT_WIDTH = 16;

endpackage

// File: rtl/psum_col_fifo.sv
// Show-ahead FIFO for one systolic-array column. A push into a full FIFO only
// lands when a pop frees a slot in the same cycle; otherwise it is reported as a drop.
module psum_col_fifo #(
    parameter int PSUM_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [PSUM_WIDTH-1:0] din,
    output logic [PSUM_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [PSUM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sa_psum_collector.sv
// Collects skewed per-column partial sums from the systolic array and emits
// them as aligned rows over a valid/ready interface, one tile at a time.
module sa_psum_collector
    import sa_psum_collector_pkg::*;
#(
    parameter int PE_SIZE       = DEF_PE_SIZE,
    parameter int PSUM_WIDTH    = DEF_PSUM_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int ROW_CNT_WIDTH = DEF_ROW_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
    input  logic [PE_SIZE-1:0]            psum_en_row_i,
    input  logic                          start_i,
    input  logic [ROW_CNT_WIDTH-1:0]      row_num_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0] out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_last_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);

    collector_state_t          state_q;
    collector_state_t          state_d;
    logic [ROW_CNT_WIDTH-1:0]  row_cnt_q;
    logic [ROW_CNT_WIDTH-1:0]  row_num_q;
    logic                      overflow_q;
    logic [PE_SIZE-1:0]        col_empty;
    logic [PE_SIZE-1:0]        col_drop;
    logic                      start_acc;
    logic                      in_busy;
    logic                      handshake;

    assign in_busy     = (state_q == BUSY);
    assign start_acc   = (state_q == IDLE) && start_i;
    assign out_valid_o = in_busy && !(|col_empty);
    assign out_last_o  = out_valid_o && (row_cnt_q == row_num_q - ROW_CNT_WIDTH'(1));
    assign handshake   = out_valid_o && out_ready_i;
    assign busy_o      = in_busy;
    assign done_o      = (state_q == DONE);
    assign overflow_o  = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (row_num_i != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (handshake && out_last_o) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An accepted start opens a fresh tile: new row target, counter and error flag cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_num_q  <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else if (start_acc) begin
            row_num_q  <= row_num_i;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (handshake) begin
                row_cnt_q <= row_cnt_q + ROW_CNT_WIDTH'(1);
            end
            if (|col_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Column j sits in the most-significant slice for j=0, matching the array output order.
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
        logic [PSUM_WIDTH-1:0] col_dout;

        psum_col_fifo #(
            .PSUM_WIDTH (PSUM_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (start_acc),
            .push  (in_busy && psum_en_row_i[PE_SIZE-1-j]),
            .pop   (handshake),
            .din   (psum_row_i[PSUM_WIDTH*(PE_SIZE-1-j) +: PSUM_WIDTH]),
            .dout  (col_dout),
            .empty (col_empty[j]),
            .drop  (col_drop[j])
        );

        assign out_data_o[PSUM_WIDTH*(PE_SIZE-1-j) +: PSUM_WIDTH] = out_valid_o ? col_dout : '0;
    end

endmodule

// File: tb/tb_sa_psum_collector.sv
// Self-checking bench for sa_psum_collector: directed tile scenarios with random
// data, compared every cycle against a queue-based behavioural model.
module tb_sa_psum_collector;

    localparam int PE = 2;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int RW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W*PE-1:0]   psum_row_i;
    logic [PE-1:0]     psum_en_row_i;
    logic              start_i;
    logic [RW-1:0]     row_num_i;
    logic [W*PE-1:0]   out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;

    always #5 clk = ~clk;

    sa_psum_collector #(
        .PE_SIZE       (PE),
        .PSUM_WIDTH    (W),
        .FIFO_DEPTH    (D),
        .ROW_CNT_WIDTH (RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psum_row_i    (psum_row_i),
        .psum_en_row_i (psum_en_row_i),
        .start_i       (start_i),
        .row_num_i     (row_num_i),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_last_o    (out_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = tile running, 2 = completion cycle.
    int           m_state;
    int           m_rows_out;
    int           m_row_num;
    bit           m_ovf;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W*PE-1:0] got_rows[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        m_state    = 0;
        m_rows_out = 0;
        m_row_num  = 0;
        m_ovf      = 1'b0;
    endtask

    // Called at a falling edge; drives one cycle, checks, advances the model, returns at the next falling edge.
    task automatic applyStimulus(input logic [1:0] en, input logic [W-1:0] d0, input logic [W-1:0] d1,
                                 input logic st, input logic [RW-1:0] rn, input logic rdy);
        bit exp_valid;
        bit exp_last;
        bit hs;
        psum_en_row_i = en;
        psum_row_i    = {d0, d1};
        start_i       = st;
        row_num_i     = rn;
        out_ready_i   = rdy;
        #1;
        exp_valid = (m_state == 1) && (q0.size() > 0) && (q1.size() > 0);
        exp_last  = exp_valid && (m_rows_out == m_row_num - 1);
        checkOutput("valid", out_valid_o, exp_valid);
        checkOutput("last", out_last_o, exp_last);
        checkOutput("busy", busy_o, m_state == 1);
        checkOutput("done", done_o, m_state == 2);
        checkOutput("overflow", overflow_o, m_ovf);
        if (exp_valid) checkOutput("data", out_data_o, {q0[0], q1[0]});
        if (out_valid_o && rdy) got_rows.push_back(out_data_o);
        hs = exp_valid && rdy;
        case (m_state)
            0: if (st) begin
                q0.delete();
                q1.delete();
                m_ovf      = 1'b0;
                m_rows_out = 0;
                m_row_num  = int'(rn);
                m_state    = (rn != 0) ? 1 : 2;
            end
            1: begin
                if (hs) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                    m_rows_out++;
                end
                if (en[1]) begin
                    if (q0.size() < D) q0.push_back(d0);
                    else m_ovf = 1'b1;
                end
                if (en[0]) begin
                    if (q1.size() < D) q1.push_back(d1);
                    else m_ovf = 1'b1;
                end
                if (hs && exp_last) m_state = 2;
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, '0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic doReset();
        psum_en_row_i = '0;
        psum_row_i    = '0;
        start_i       = 1'b0;
        row_num_i     = '0;
        out_ready_i   = 1'b0;
        rst_n         = 1'b0;
        #1;
        checkOutput("rst_valid", out_valid_o, 1'b0);
        checkOutput("rst_last", out_last_o, 1'b0);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_done", done_o, 1'b0);
        checkOutput("rst_overflow", overflow_o, 1'b0);
        checkOutput("rst_data", out_data_o, '0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] v[5];
        logic [W-1:0] x[5];
        logic [W-1:0] sent0[$];
        logic [W-1:0] sent1[$];
        bit           seen_done;
        bit           e0;
        bit           e1;
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        int           base;

        rst_n = 1'b0;
        psum_en_row_i = '0;
        psum_row_i = '0;
        start_i = 1'b0;
        row_num_i = '0;
        out_ready_i = 1'b0;
        modelReset();
        @(negedge clk);
        doReset();

        $display("[TB] skewed arrival");
        got_rows.delete();
        applyStimulus(2'b00, '0, '0, 1'b1, 16'd2, 1'b1);
        applyStimulus(2'b10, 32'h11, '0, 1'b0, '0, 1'b1);
        applyStimulus(2'b11, 32'h12, 32'h21, 1'b0, '0, 1'b1);
        applyStimulus(2'b01, '0, 32'h22, 1'b0, '0, 1'b1);
        idleCycles(3);
        checkOutput("skew_count", got_rows.size(), 2);
        if (got_rows.size() == 2) begin
            checkOutput("skew_row0", got_rows[0], 64'h00000011_00000021);
            checkOutput("skew_row1", got_rows[1], 64'h00000012_00000022);
        end

        $display("[TB] backpressure overflow");
        got_rows.delete();
        for (int i = 0; i < 5; i++) begin
            v[i] = $urandom;
            x[i] = $urandom;
        end
        applyStimulus(2'b00, '0, '0, 1'b1, 16'd4, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(2'b10, v[i], '0, 1'b0, '0, 1'b0);
        checkOutput("bp_overflow", overflow_o, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(2'b01, '0, x[i], 1'b0, '0, 1'b1);
        idleCycles(4);
        checkOutput("bp_count", got_rows.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_rows.size()) checkOutput("bp_order", got_rows[i], {v[i], x[i]});
        end

        $display("[TB] full with simultaneous pop");
        got_rows.delete();
        for (int i = 0; i < 5; i++) begin
            v[i] = $urandom;
            x[i] = $urandom;
        end
        applyStimulus(2'b00, '0, '0, 1'b1, 16'd5, 1'b0);
        checkOutput("fp_ovf_cleared", overflow_o, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, v[i], x[i], 1'b0, '0, 1'b0);
        applyStimulus(2'b10, v[3], '0, 1'b0, '0, 1'b0);
        applyStimulus(2'b11, v[4], x[3], 1'b0, '0, 1'b1);
        checkOutput("fp_no_overflow", overflow_o, 1'b0);
        applyStimulus(2'b01, '0, x[4], 1'b0, '0, 1'b1);
        idleCycles(6);
        checkOutput("fp_count", got_rows.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_rows.size()) checkOutput("fp_order", got_rows[i], {v[i], x[i]});
        end

        $display("[TB] zero-row tile");
        got_rows.delete();
        applyStimulus(2'($urandom), $urandom, $urandom, 1'b1, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(2'($urandom), $urandom, $urandom, 1'b0, '0, 1'b1);
        checkOutput("zero_rows", got_rows.size(), 0);

        $display("[TB] reset mid-tile");
        got_rows.delete();
        applyStimulus(2'b00, '0, '0, 1'b1, 16'd3, 1'b1);
        applyStimulus(2'b11, $urandom, $urandom, 1'b0, '0, 1'b1);
        applyStimulus(2'b11, $urandom, $urandom, 1'b0, '0, 1'b1);
        checkOutput("mid_rows_before_reset", got_rows.size(), 1);
        doReset();
        got_rows.delete();
        r0 = $urandom;
        r1 = $urandom;
        applyStimulus(2'b00, '0, '0, 1'b1, 16'd1, 1'b1);
        applyStimulus(2'b11, r0, r1, 1'b0, '0, 1'b1);
        idleCycles(3);
        checkOutput("post_reset_count", got_rows.size(), 1);
        if (got_rows.size() == 1) checkOutput("post_reset_row", got_rows[0], {r0, r1});

        $display("[TB] wrap-around, 10 rows");
        got_rows.delete();
        sent0.delete();
        sent1.delete();
        seen_done = 1'b0;
        applyStimulus(2'b00, '0, '0, 1'b1, 16'd10, 1'b0);
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            e0 = (sent0.size() < 10) && (q0.size() < D) && ($urandom_range(0, 3) != 0);
            e1 = (sent1.size() < 10) && (q1.size() < D) && ($urandom_range(0, 3) != 0);
            r0 = $urandom;
            r1 = $urandom;
            if (e0) sent0.push_back(r0);
            if (e1) sent1.push_back(r1);
            applyStimulus({e0, e1}, r0, r1, 1'b0, '0, 1'(cyc));
            seen_done = done_o;
        end
        checkOutput("wrap_done_seen", seen_done, 1'b1);
        checkOutput("wrap_count", got_rows.size(), 10);
        base = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < got_rows.size() && i < sent0.size() && i < sent1.size())
                checkOutput("wrap_order", got_rows[i], {sent0[i], sent1[i]});
        end
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
